// File: rtl/tetris_piece_ctrl.sv
// Falling-piece sequencer: spawns pieces, proposes moves to an external
// collision checker, commits or rejects them and hands locked pieces to the board.
package tetris_piece_pkg;
  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_type_t;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rotation_t;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_SOFT_DROP = 3'd4
  } command_t;

  typedef struct packed {
    piece_type_t piece;
    rotation_t   rot;
    logic [3:0]  x;
    logic [4:0]  y;
  } active_piece_t;
endpackage

module tetris_piece_ctrl
  import tetris_piece_pkg::*;
#(
  parameter logic [3:0] SPAWN_X = 4'd3,
  parameter logic [4:0] SPAWN_Y = 5'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  input  logic          gravity_tick,
  input  logic [2:0]    next_piece,
  output logic          piece_req,
  output logic          chk_req,
  output active_piece_t chk_piece,
  input  logic          chk_ack,
  input  logic          chk_collide,
  output logic          lock_req,
  input  logic          lock_ack,
  output active_piece_t active_piece,
  output logic          piece_valid,
  output logic          game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPAWN     = 3'd1,
    S_WAIT      = 3'd2,
    S_CHECK     = 3'd3,
    S_LOCK      = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    KIND_SPAWN = 2'd0,
    KIND_DOWN  = 2'd1,
    KIND_SIDE  = 2'd2
  } kind_t;

  localparam active_piece_t RESET_PIECE = '{piece: PIECE_I, rot: ROT_0, x: SPAWN_X, y: SPAWN_Y};

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  active_piece_t cand_q, cand_d;
  active_piece_t active_q, active_d;
  logic          valid_q, valid_d;
  logic          over_q, over_d;
  logic          grav_pend, cmd_pend;
  command_t      cmd_q;
  command_t      cmd_in;
  logic          running, grav_ev, cmd_ev;
  logic          launch_grav, launch_cmd, drop_pend;
  active_piece_t down_cand;

  assign cmd_in    = command_t'(cmd);
  assign running   = (state_q != S_IDLE) && (state_q != S_GAME_OVER);
  assign grav_ev   = gravity_tick && running;
  assign cmd_ev    = cmd_valid && running &&
                     ((cmd_in == CMD_LEFT) || (cmd_in == CMD_RIGHT) ||
                      (cmd_in == CMD_ROTATE) || (cmd_in == CMD_SOFT_DROP));
  assign down_cand = '{piece: active_q.piece, rot: active_q.rot,
                       x: active_q.x, y: active_q.y + 5'd1};

  assign chk_piece    = cand_q;
  assign active_piece = active_q;
  assign piece_valid  = valid_q;
  assign game_over    = over_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Edge guards reject sideways moves silently; a down move off the floor locks directly.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cand_d      = cand_q;
    active_d    = active_q;
    valid_d     = valid_q;
    over_d      = over_q;
    launch_grav = 1'b0;
    launch_cmd  = 1'b0;
    drop_pend   = 1'b0;
    piece_req   = 1'b0;
    chk_req     = 1'b0;
    lock_req    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        piece_req = 1'b1;
        cand_d    = '{piece: piece_type_t'(next_piece), rot: ROT_0, x: SPAWN_X, y: SPAWN_Y};
        kind_d    = KIND_SPAWN;
        state_d   = S_CHECK;
      end
      S_WAIT: begin
        if (grav_pend) begin
          launch_grav = 1'b1;
          kind_d      = KIND_DOWN;
          cand_d      = down_cand;
          state_d     = (active_q.y == 5'd31) ? S_LOCK : S_CHECK;
        end else if (cmd_pend) begin
          launch_cmd = 1'b1;
          case (cmd_q)
            CMD_LEFT: begin
              kind_d = KIND_SIDE;
              if (active_q.x != 4'd0) begin
                cand_d   = active_q;
                cand_d.x = active_q.x - 4'd1;
                state_d  = S_CHECK;
              end
            end
            CMD_RIGHT: begin
              kind_d = KIND_SIDE;
              if (active_q.x != 4'd15) begin
                cand_d   = active_q;
                cand_d.x = active_q.x + 4'd1;
                state_d  = S_CHECK;
              end
            end
            CMD_ROTATE: begin
              kind_d     = KIND_SIDE;
              cand_d     = active_q;
              cand_d.rot = rotation_t'(active_q.rot + 2'd1);
              state_d    = S_CHECK;
            end
            CMD_SOFT_DROP: begin
              kind_d  = KIND_DOWN;
              cand_d  = down_cand;
              state_d = (active_q.y == 5'd31) ? S_LOCK : S_CHECK;
            end
            default: state_d = S_WAIT;
          endcase
        end
      end
      S_CHECK: begin
        chk_req = 1'b1;
        if (chk_ack) begin
          if (!chk_collide) begin
            active_d = cand_q;
            if (kind_q == KIND_SPAWN) valid_d = 1'b1;
            state_d = S_WAIT;
          end else begin
            case (kind_q)
              KIND_DOWN:  state_d = S_LOCK;
              KIND_SPAWN: begin
                over_d  = 1'b1;
                state_d = S_GAME_OVER;
              end
              default:    state_d = S_WAIT;
            endcase
          end
        end
      end
      S_LOCK: begin
        lock_req = 1'b1;
        if (lock_ack) begin
          valid_d   = 1'b0;
          drop_pend = 1'b1;
          state_d   = S_SPAWN;
        end
      end
      S_GAME_OVER: begin
        if (start) begin
          over_d  = 1'b0;
          state_d = S_SPAWN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh event arriving in its own launch cycle stays pending for the next move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q    <= KIND_SPAWN;
      cand_q    <= '0;
      active_q  <= RESET_PIECE;
      valid_q   <= 1'b0;
      over_q    <= 1'b0;
      grav_pend <= 1'b0;
      cmd_pend  <= 1'b0;
      cmd_q     <= CMD_NONE;
    end else begin
      kind_q   <= kind_d;
      cand_q   <= cand_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      over_q   <= over_d;
      if (drop_pend) begin
        grav_pend <= 1'b0;
        cmd_pend  <= 1'b0;
      end else begin
        if (grav_ev)          grav_pend <= 1'b1;
        else if (launch_grav) grav_pend <= 1'b0;
        if (cmd_ev) begin
          cmd_pend <= 1'b1;
          cmd_q    <= cmd_in;
        end else if (launch_cmd) begin
          cmd_pend <= 1'b0;
        end
      end
    end
  end

endmodule
